mat_stream_tx: RTL and testbench

MAT_STREAM_TX -- requirements
Module: mat_stream_tx

---
 rtl/pool_pkg.sv | 11 +
 rtl/mat_raster_cnt.sv | 50 +++++
 rtl/mat_stream_tx.sv | 147 ++++++++++++++
 tb/tb_mat_stream_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared pooling/streaming constants and FSM state type (also used by avg_pool_single).
package pool_pkg;
  localparam int POOL_DATAWIDTH     = 32;
  localparam int POOL_MAT_DIMENSION = 13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } pool_state_t;
endpackage

// File: rtl/mat_raster_cnt.sv
// Raster-order row/col counter with clear, enable and wrap; exposes the next index
// so the caller can prefetch the element it will present after an advance.
module mat_raster_cnt
  import pool_pkg::*;
#(
  parameter int MAT_DIMENSION = POOL_MAT_DIMENSION,
  parameter int AW            = $clog2(MAT_DIMENSION)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_row,
  output logic [AW-1:0] o_col,
  output logic [AW-1:0] o_nxt_row,
  output logic [AW-1:0] o_nxt_col,
  output logic          o_nxt_last
);
  localparam logic [AW-1:0] LAST = AW'(MAT_DIMENSION - 1);

  logic [AW-1:0] r_row;
  logic [AW-1:0] r_col;
  logic          w_col_wrap;

  always_comb begin
    w_col_wrap = (r_col == LAST);
    o_nxt_col  = w_col_wrap ? '0 : r_col + AW'(1);
    o_nxt_row  = r_row;
    if (w_col_wrap) begin
      o_nxt_row = (r_row == LAST) ? '0 : r_row + AW'(1);
    end
    o_nxt_last = (o_nxt_row == LAST) && (o_nxt_col == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      r_row <= o_nxt_row;
      r_col <= o_nxt_col;
    end
  end

  assign o_row = r_row;
  assign o_col = r_col;
endmodule

// File: rtl/mat_stream_tx.sv
// Stores an N x N matrix and streams it in raster order over a valid/ready port.
// Optional XOR checksum of each stream is compiled in with MAT_STREAM_TX_CKSUM_EN.
module mat_stream_tx
  import pool_pkg::*;
#(
  parameter int DATAWIDTH     = POOL_DATAWIDTH,
  parameter int MAT_DIMENSION = POOL_MAT_DIMENSION
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [$clog2(MAT_DIMENSION)-1:0] wr_row,
  input  logic [$clog2(MAT_DIMENSION)-1:0] wr_col,
  input  logic [DATAWIDTH-1:0]             wr_data,
  input  logic                             start,
  output logic                             busy,
  output logic [DATAWIDTH-1:0]             out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(MAT_DIMENSION)-1:0] out_row,
  output logic [$clog2(MAT_DIMENSION)-1:0] out_col,
  output logic                             out_last,
  output logic                             done,
  output logic [DATAWIDTH-1:0]             cksum
);
  localparam int AW    = $clog2(MAT_DIMENSION);
  localparam int DEPTH = MAT_DIMENSION * MAT_DIMENSION;
  localparam int IW    = $clog2(DEPTH);

  logic [DATAWIDTH-1:0] r_mem [DEPTH];
  pool_state_t          r_state;
  logic                 r_busy;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_done;
  logic [DATAWIDTH-1:0] r_data;

  logic          w_wr_ok;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;
  logic          w_clr;
  logic          w_xfer;
  logic [AW-1:0] w_nxt_row;
  logic [AW-1:0] w_nxt_col;
  logic          w_nxt_last;

  assign w_wr_ok  = wr_en && (r_state == ST_IDLE) &&
                    (int'(wr_row) < MAT_DIMENSION) && (int'(wr_col) < MAT_DIMENSION);
  assign w_wr_idx = IW'(int'(wr_row) * MAT_DIMENSION + int'(wr_col));
  assign w_rd_idx = IW'(int'(w_nxt_row) * MAT_DIMENSION + int'(w_nxt_col));
  assign w_clr    = (r_state == ST_IDLE) && start;
  assign w_xfer   = (r_state == ST_STREAM) && r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  mat_raster_cnt #(
    .MAT_DIMENSION (MAT_DIMENSION),
    .AW            (AW)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_en       (w_xfer),
    .o_row      (out_row),
    .o_col      (out_col),
    .o_nxt_row  (w_nxt_row),
    .o_nxt_col  (w_nxt_col),
    .o_nxt_last (w_nxt_last)
  );

  // out_data is prefetched from the counter's next index so it lines up with out_row/out_col.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= ST_STREAM;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_last  <= (MAT_DIMENSION == 1);
            r_data  <= r_mem[0];
          end
        end
        ST_STREAM: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_data <= r_mem[w_rd_idx];
              r_last <= w_nxt_last;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign done      = r_done;
  assign out_data  = r_data;

`ifdef MAT_STREAM_TX_CKSUM_EN
  logic [DATAWIDTH-1:0] r_acc;
  logic [DATAWIDTH-1:0] r_cksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_cksum <= '0;
    end else if (w_clr) begin
      r_acc <= '0;
    end else if (w_xfer) begin
      r_acc <= r_acc ^ r_data;
      if (r_last) begin
        r_cksum <= r_acc ^ r_data;
      end
    end
  end

  assign cksum = r_cksum;
`else
  assign cksum = '0;
`endif
endmodule

// File: tb/tb_mat_stream_tx.sv
// Directed bench for mat_stream_tx (N=13, 32-bit): raster order, stalls, reset, ignored strobes, checksum.
module tb_mat_stream_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_row;
  logic [3:0]  wr_col;
  logic [31:0] wr_data;
  logic        start;
  logic        busy;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_row;
  logic [3:0]  out_col;
  logic        out_last;
  logic        done;
  logic [31:0] cksum;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt, se, cd, e;

  logic [31:0] rx_data [169];
  logic [3:0]  rx_row  [169];
  logic [3:0]  rx_col  [169];
  logic        rx_last [169];

  typedef struct {
    logic [3:0]  r;
    logic [3:0]  c;
    logic [31:0] d;
    int          chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [6];

`ifdef MAT_STREAM_TX_CKSUM_EN
  localparam logic [31:0] EXP_CKSUM = 32'h1234a987;
`else
  localparam logic [31:0] EXP_CKSUM = 32'h0;
`endif

  always #5 clk = ~clk;

  mat_stream_tx #(
    .DATAWIDTH     (32),
    .MAT_DIMENSION (13)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .start     (start),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .done      (done),
    .cksum     (cksum)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] r, input logic [3:0] c, input logic [31:0] d);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
    step;
    wr_en = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  // Collects transfers until done; inject_at pulses start + wr_en([0][0]=0) on that cycle.
  task automatic stream(input bit toggle, input int inject_at,
                        output int n, output int stall_err, output int cyc_done);
    logic [40:0] prev;
    logic        pstall;
    n = 0; stall_err = 0; cyc_done = -1; pstall = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (pstall && ({out_row, out_col, out_data, out_last} !== prev)) stall_err++;
      if (done) begin
        cyc_done = cyc;
        break;
      end
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      start   = (cyc == inject_at);
      wr_en   = (cyc == inject_at);
      wr_row  = '0; wr_col = '0; wr_data = '0;
      if (out_valid && out_ready) begin
        if (n < 169) begin
          rx_data[n] = out_data; rx_row[n] = out_row;
          rx_col[n]  = out_col;  rx_last[n] = out_last;
        end
        n++;
      end
      pstall = out_valid && !out_ready;
      prev   = {out_row, out_col, out_data, out_last};
      step;
    end
    start = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{r: 4'd2,  c: 4'd3,  d: 32'ha5a50001, chk: 29,  exp: 32'ha5a50001};
    tbl[1] = '{r: 4'd0,  c: 4'd13, d: 32'hdead0001, chk: 13,  exp: 32'd13};
    tbl[2] = '{r: 4'd13, c: 4'd0,  d: 32'hdead0002, chk: 156, exp: 32'd156};
    tbl[3] = '{r: 4'd15, c: 4'd2,  d: 32'hdead0004, chk: 2,   exp: 32'd2};
    tbl[4] = '{r: 4'd12, c: 4'd12, d: 32'hc0de0005, chk: 168, exp: 32'hc0de0005};
    tbl[5] = '{r: 4'd7,  c: 4'd0,  d: 32'h00000777, chk: 91,  exp: 32'h00000777};

    rst = 1'b1; wr_en = 1'b0; start = 1'b0; out_ready = 1'b1;
    wr_row = '0; wr_col = '0; wr_data = '0;
    step; step;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    chk("rst_cksum", cksum, 0);
    rst = 1'b0;
    step;

    // All-ones-float matrix, ready held high
    for (int r = 0; r < 13; r++)
      for (int c = 0; c < 13; c++) load(4'(r), 4'(c), 32'h3f800000);
    do_start;
    chk("t1_busy", busy, 1);
    chk("t1_valid", out_valid, 1);
    stream(1'b0, -1, cnt, se, cd);
    chk("t1_count", cnt, 169);
    chk("t1_done_cycle", cd, 169);
    e = 0;
    for (int i = 0; i < 169; i++)
      if (rx_data[i] !== 32'h3f800000 || rx_last[i] !== (i == 168) ||
          rx_row[i] !== 4'(i / 13) || rx_col[i] !== 4'(i % 13)) e++;
    chk("t1_elem_errs", e, 0);
    chk("t1_busy_done", busy, 0);
    chk("t1_valid_done", out_valid, 0);
    step;
    chk("t1_done_pulse", done, 0);

    // Indexed matrix, ready toggling
    for (int r = 0; r < 13; r++)
      for (int c = 0; c < 13; c++) load(4'(r), 4'(c), 32'(r * 13 + c));
    do_start;
    stream(1'b1, -1, cnt, se, cd);
    chk("t2_count", cnt, 169);
    chk("t2_stall_errs", se, 0);
    chk("t2_done_cycle", cd, 337);
    e = 0;
    for (int i = 0; i < 169; i++)
      if (rx_data[i] !== 32'(i) || rx_row[i] !== 4'(i / 13) || rx_col[i] !== 4'(i % 13)) e++;
    chk("t2_seq_errs", e, 0);
    step;

    // Reset after 50 transfers
    load(4'd0, 4'd0, 32'h55);
    do_start;
    out_ready = 1'b1;
    repeat (50) step;
    chk("t3_row50", out_row, 3);
    chk("t3_col50", out_col, 11);
    chk("t3_data50", out_data, 50);
    rst = 1'b1;
    #1;
    chk("t3_async_valid", out_valid, 0);
    chk("t3_async_busy", busy, 0);
    chk("t3_async_row", out_row, 0);
    chk("t3_async_col", out_col, 0);
    chk("t3_async_data", out_data, 0);
    step;
    rst = 1'b0;
    step;
    chk("t3_idle_valid", out_valid, 0);
    do_start;
    chk("t3_replay_data", out_data, 32'h55);
    chk("t3_replay_row", out_row, 0);
    chk("t3_replay_col", out_col, 0);

    // start and wr_en pulsed mid-stream must be ignored
    stream(1'b0, 5, cnt, se, cd);
    chk("t4_count", cnt, 169);
    chk("t4_done_cycle", cd, 169);
    e = 0;
    for (int i = 0; i < 169; i++)
      if (rx_data[i] !== ((i == 0) ? 32'h55 : 32'(i)) ||
          rx_row[i] !== 4'(i / 13) || rx_col[i] !== 4'(i % 13)) e++;
    chk("t4_seq_errs", e, 0);
    step;
    do_start;
    chk("t4_kept_00", out_data, 32'h55);
    stream(1'b0, -1, cnt, se, cd);
    step;

    // Table of writes (some out of range), then checked against the streamed image
    for (int i = 0; i < 6; i++) load(tbl[i].r, tbl[i].c, tbl[i].d);
    do_start;
    stream(1'b0, -1, cnt, se, cd);
    chk("tbl_count", cnt, 169);
    for (int i = 0; i < 6; i++)
      chk($sformatf("tbl_%0d_idx%0d", i, tbl[i].chk), rx_data[tbl[i].chk], tbl[i].exp);
    step;

    // Checksum vector
    for (int r = 0; r < 13; r++)
      for (int c = 0; c < 13; c++) load(4'(r), 4'(c), 32'h0);
    load(4'd0, 4'd0, 32'h12345678);
    load(4'd0, 4'd1, 32'h0000ffff);
    do_start;
    stream(1'b0, -1, cnt, se, cd);
    chk("t5_count", cnt, 169);
    step;
    chk("t5_cksum", cksum, EXP_CKSUM);
    repeat (3) step;
    chk("t5_cksum_hold", cksum, EXP_CKSUM);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
